// File: rtl/dbc_pkg.sv
// Shared encodings, FSM states, GPIO register map and lane helpers for data_bus_ctrl.
package dbc_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_RESP    = 2'b10
  } state_e;

  // GPIO registers are indexed by addr[3:2]
  localparam logic [1:0] GPIO_REG_OUT  = 2'd0;
  localparam logic [1:0] GPIO_REG_DIR  = 2'd1;
  localparam logic [1:0] GPIO_REG_IN   = 2'd2;
  localparam logic [1:0] GPIO_REG_RSVD = 2'd3;

  localparam logic [31:0] DBC_RAM_BASE_DFLT  = 32'h0000_0000;
  localparam logic [31:0] DBC_GPIO_BASE_DFLT = 32'h1000_0000;

  function automatic logic [3:0] lane_be(size_e sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: lane_be = 4'b0001 << off;
      SZ_HALF: lane_be = 4'b0011 << {off[1], 1'b0};
      SZ_WORD: lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(size_e sz, logic [31:0] wd);
    case (sz)
      SZ_BYTE: lane_rep = {4{wd[7:0]}};
      SZ_HALF: lane_rep = {2{wd[15:0]}};
      default: lane_rep = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(logic [31:0] w, logic [1:0] off, size_e sz, logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: load_extend = {{24{b[7] & ~uns}}, b};
      SZ_HALF: load_extend = {{16{h[15] & ~uns}}, h};
      default: load_extend = w;
    endcase
  endfunction

endpackage

// File: rtl/data_bus_ctrl_if.sv
// Load/store request/response bundle between the core LSU (master) and data_bus_ctrl (slave).
interface data_bus_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, we, size, uns, addr, wdata,
    input  busy, ack, err, rdata
  );

  modport slave (
    input  req, we, size, uns, addr, wdata,
    output busy, ack, err, rdata
  );
endinterface

// File: rtl/dbc_gpio_bank.sv
// GPIO OUT/DIR registers, 2-flop input synchroniser and combinational register read mux.
module dbc_gpio_bank
  import dbc_pkg::*;
#(
  parameter int GPIO_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  input  logic [1:0]        reg_sel_i,
  output logic [31:0]       rdata_o,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe
);

  // Bits at and above GPIO_W are forced to zero so they read back as 0
  localparam logic [31:0] PIN_MASK = 32'((64'd1 << GPIO_W) - 64'd1);

  logic [31:0]       out_q, out_d;
  logic [31:0]       dir_q, dir_d;
  logic [31:0]       bit_mask;
  logic [GPIO_W-1:0] sync1_q, sync2_q;

  assign bit_mask = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (we_i && (reg_sel_i == GPIO_REG_OUT)) out_d = ((out_q & ~bit_mask) | (wdata_i & bit_mask)) & PIN_MASK;
    if (we_i && (reg_sel_i == GPIO_REG_DIR)) dir_d = ((dir_q & ~bit_mask) | (wdata_i & bit_mask)) & PIN_MASK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q   <= '0;
      dir_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      sync1_q <= gpio_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    case (reg_sel_i)
      GPIO_REG_OUT: rdata_o = out_q;
      GPIO_REG_DIR: rdata_o = dir_q;
      GPIO_REG_IN:  rdata_o = 32'(sync2_q);
      default:      rdata_o = '0;
    endcase
  end

  assign gpio_o  = out_q[GPIO_W-1:0];
  assign gpio_oe = dir_q[GPIO_W-1:0];

endmodule

// File: rtl/rl_ram_1r1w_generic.sv
// Synchronous 1R1W word RAM with byte-lane write enables; read data registered, held while re_i is low.
module rl_ram_1r1w_generic #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// Data-side bus controller: one LSU access at a time into a RAM window or GPIO register window.
// Build option DBC_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of aligning down.
module data_bus_ctrl
  import dbc_pkg::*;
#(
  parameter int          RAM_ABITS = 12,
  parameter logic [31:0] RAM_BASE  = DBC_RAM_BASE_DFLT,
  parameter logic [31:0] GPIO_BASE = DBC_GPIO_BASE_DFLT,
  parameter int          GPIO_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  data_bus_ctrl_if.slave    bus,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe
);

  state_e      state_q;
  logic        ack_q, err_q;
  logic [31:0] rdata_q;
  size_e       size_q;
  logic        uns_q;
  logic [1:0]  off_q;

  size_e       sz;
  logic [1:0]  off;
  logic        ram_hit, gpio_hit, gpio_rsvd, mis_fault, fault;
  logic        accept, ram_we, ram_re, gpio_we;
  logic [3:0]  be;
  logic [31:0] wd_rep, ram_dout, gpio_dout;

  assign sz  = size_e'(bus.size);
  // Lane offset with the bits a half/word access ignores cleared (align-down)
  assign off = {bus.addr[1] & (sz != SZ_WORD), bus.addr[0] & (sz == SZ_BYTE)};

  assign ram_hit   = (bus.addr >> RAM_ABITS) == (RAM_BASE >> RAM_ABITS);
  assign gpio_hit  = bus.addr[31:4] == GPIO_BASE[31:4];
  assign gpio_rsvd = gpio_hit && (bus.addr[3:2] == GPIO_REG_RSVD);

`ifdef DBC_MISALIGN_TRAP_EN
  assign mis_fault = ((sz == SZ_HALF) && bus.addr[0]) ||
                     ((sz == SZ_WORD) && (bus.addr[1:0] != 2'b00));
`else
  assign mis_fault = 1'b0;
`endif

  assign fault   = (sz == SZ_ILL) || !(ram_hit || gpio_hit) || gpio_rsvd || mis_fault;
  assign accept  = (state_q == ST_IDLE) && bus.req;
  assign ram_we  = accept && bus.we && ram_hit && !fault;
  assign ram_re  = accept && !bus.we && ram_hit && !fault;
  assign gpio_we = accept && bus.we && gpio_hit && !fault;
  assign be      = lane_be(sz, off);
  assign wd_rep  = lane_rep(sz, bus.wdata);

  rl_ram_1r1w_generic #(
    .AW (RAM_ABITS - 2)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (be),
    .waddr_i (bus.addr[RAM_ABITS-1:2]),
    .wdata_i (wd_rep),
    .re_i    (ram_re),
    .raddr_i (bus.addr[RAM_ABITS-1:2]),
    .rdata_o (ram_dout)
  );

  dbc_gpio_bank #(
    .GPIO_W (GPIO_W)
  ) u_gpio (
    .clk       (clk),
    .rst       (rst),
    .we_i      (gpio_we),
    .be_i      (be),
    .wdata_i   (wd_rep),
    .reg_sel_i (bus.addr[3:2]),
    .rdata_o   (gpio_dout),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_oe   (gpio_oe)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      off_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req) begin
            size_q <= sz;
            uns_q  <= bus.uns;
            off_q  <= off;
            if (ram_re) begin
              state_q <= ST_RD_WAIT;
            end else begin
              state_q <= ST_RESP;
              ack_q   <= 1'b1;
              err_q   <= fault;
              rdata_q <= (fault || bus.we) ? 32'd0 : load_extend(gpio_dout, off, sz, bus.uns);
            end
          end
        end
        ST_RD_WAIT: begin
          state_q <= ST_RESP;
          ack_q   <= 1'b1;
          rdata_q <= load_extend(ram_dout, off_q, size_q, uns_q);
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Randomised self-checking bench for data_bus_ctrl against a byte-array memory / register model.
`timescale 1ns/1ps
module tb_data_bus_ctrl;

  localparam int          GPIO_W = 20;
  localparam logic [31:0] GMASK  = 32'h000F_FFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [GPIO_W-1:0] gpio_i;
  logic [GPIO_W-1:0] gpio_o;
  logic [GPIO_W-1:0] gpio_oe;

  data_bus_ctrl_if bus ();

  data_bus_ctrl #(
    .RAM_ABITS (12),
    .RAM_BASE  (32'h0000_0000),
    .GPIO_BASE (32'h1000_0000),
    .GPIO_W    (GPIO_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state: RAM as bytes, GPIO registers as plain words, pins as seen after sync
  logic [7:0]  mem_m [4096];
  logic [31:0] out_m, dir_m, pins_m;

  function automatic logic [31:0] extend(logic [31:0] v, int n, logic u);
    if (n == 1) return u ? (v & 32'hFF)   : 32'($signed(v[7:0]));
    if (n == 2) return u ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
    return v;
  endfunction

  task automatic model(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] wd, output logic e, output logic [31:0] rd, output int lat);
    int          n;
    logic [31:0] aa, v, rg;
    logic        ram, gp;
    n   = 1 << sz;
    ram = (a < 32'h1000);
    gp  = (a >= 32'h1000_0000) && (a <= 32'h1000_000F);
    e   = (!ram && !gp) || (sz == 2'd3) || (gp && a[3:2] == 2'd3);
`ifdef DBC_MISALIGN_TRAP_EN
    if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) e = 1'b1;
`endif
    rd  = 32'd0;
    lat = 1;
    if (e) return;
    aa = a - (a % n);
    if (ram) begin
      if (w) begin
        for (int k = 0; k < n; k++) mem_m[aa + k] = wd[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(mem_m[aa + k]) << (8 * k));
        rd  = extend(v, n, u);
        lat = 2;
      end
    end else begin
      rg = (a[3:2] == 2'd0) ? out_m : (a[3:2] == 2'd1) ? dir_m : pins_m;
      if (w) begin
        for (int k = 0; k < n; k++) rg[8*(int'(aa[1:0]) + k) +: 8] = wd[8*k +: 8];
        rg = rg & GMASK;
        if (a[3:2] == 2'd0) out_m = rg;
        if (a[3:2] == 2'd1) dir_m = rg;
      end else begin
        rd = extend(rg >> (8 * int'(aa[1:0])), n, u);
      end
    end
  endtask

  // Starts and ends #1 after a rising edge with the controller idle
  task automatic bus_op(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input bit noise, output logic [31:0] rd_obs);
    logic        e_exp;
    logic [31:0] rd_exp;
    int          lat_exp, lat;
    model(w, sz, u, a, wd, e_exp, rd_exp, lat_exp);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.uns = u; bus.addr = a; bus.wdata = wd;
    @(posedge clk); #1;
    if (noise) begin
      bus.we = 1'b1; bus.size = 2'd2;
      bus.addr = 32'($urandom_range(0, 63)) << 2;
      bus.wdata = $urandom;
    end else begin
      bus.req = 1'b0;
    end
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    lat = 1;
    while (!bus.ack && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    bus.req = 1'b0;
    check($sformatf("ack_latency@%h", a), lat, lat_exp);
    check($sformatf("err@%h", a), 32'(bus.err), 32'(e_exp));
    check($sformatf("rdata@%h", a), bus.rdata, rd_exp);
    check("gpio_o", 32'(gpio_o), out_m);
    check("gpio_oe", 32'(gpio_oe), dir_m);
    rd_obs = bus.rdata;
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(bus.ack), 32'd0);
    check("idle_after_ack", 32'(bus.busy), 32'd0);
    check("rdata_held", bus.rdata, rd_exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, r0;
    logic        e_d;
    logic [31:0] rd_d;
    int          lat_d;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.uns = 1'b0; bus.addr = '0; bus.wdata = '0;
    gpio_i = '0;
    out_m = '0; dir_m = '0; pins_m = '0;

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_gpio_o", 32'(gpio_o), 32'd0);
    check("rst_gpio_oe", 32'(gpio_oe), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 64; i++) bus_op(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom, 1'b0, r);
    for (int i = 0; i < 4; i++) bus_op(1'b1, 2'd2, 1'b0, 32'h0FF0 + 32'(4 * i), $urandom, 1'b0, r);

    bus_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, r);
    bus_op(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, r);
    check("lb_signed_0x13", r, 32'hFFFF_FFDE);
    bus_op(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, r);
    check("lbu_0x13", r, 32'h0000_00DE);
    bus_op(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_1234, 1'b0, r);
    bus_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, r);
    check("lw_0x20_upper_half", r >> 16, 32'h1234);

    bus_op(1'b1, 2'd2, 1'b0, 32'h1000_0004, 32'h0000_00FF, 1'b0, r);
    check("gpio_oe_ff", 32'(gpio_oe), 32'hFF);
    bus_op(1'b1, 2'd2, 1'b0, 32'h1000_0000, 32'h0000_00A5, 1'b0, r);
    check("gpio_o_a5", 32'(gpio_o), 32'hA5);
    bus_op(1'b1, 2'd2, 1'b0, 32'h1000_0000, 32'hFFFF_FFFF, 1'b0, r);
    check("gpio_o_upper_masked", 32'(gpio_o), GMASK);
    bus_op(1'b0, 2'd2, 1'b0, 32'h1000_0000, 32'h0, 1'b0, r);
    check("gpio_out_read_masked", r, GMASK);

    gpio_i = 20'h0003C;
    @(posedge clk); #1;
    bus_op(1'b0, 2'd2, 1'b0, 32'h1000_0008, 32'h0, 1'b0, r);
    check("gpio_in_one_clk_old", r, 32'h0);
    pins_m = 32'h3C;
    bus_op(1'b0, 2'd2, 1'b0, 32'h1000_0008, 32'h0, 1'b0, r);
    check("gpio_in_3c", r, 32'h3C);
    gpio_i = GPIO_W'($urandom);
    repeat (2) @(posedge clk);
    #1;
    pins_m = 32'(gpio_i);
    bus_op(1'b0, 2'd2, 1'b0, 32'h1000_0008, 32'h0, 1'b0, r);
    bus_op(1'b1, 2'd2, 1'b0, 32'h1000_0008, 32'hFFFF_FFFF, 1'b0, r);
    bus_op(1'b0, 2'd2, 1'b0, 32'h1000_000C, 32'h0, 1'b0, r);

    bus_op(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, 1'b0, r0);
    bus_op(1'b0, 2'd2, 1'b0, 32'h2000_0000, 32'h0, 1'b0, r);
    check("unmapped_rdata", r, 32'h0);
    bus_op(1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'h1111_1111, 1'b0, r);
    bus_op(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 1'b0, r);
    bus_op(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, 1'b0, r);
    check("ram_unchanged_after_err", r, r0);
    bus_op(1'b0, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0, 1'b0, r);
    bus_op(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 1'b0, r);
    bus_op(1'b0, 2'd2, 1'b0, 32'h1000_0010, 32'h0, 1'b0, r);
    bus_op(1'b0, 2'd2, 1'b0, 32'h0FFF_FFFC, 32'h0, 1'b0, r);

    bus_op(1'b1, 2'd2, 1'b0, 32'h0000_0002, 32'hCAFE_F00D, 1'b0, r);
    bus_op(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, 1'b0, r);
`ifdef DBC_MISALIGN_TRAP_EN
    check("misaligned_store_trapped", r, r0);
`else
    check("misaligned_store_aligned", r, 32'hCAFE_F00D);
`endif

    bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2; bus.uns = 1'b0; bus.addr = 32'h10;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("rd_wait_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_ack", 32'(bus.ack), 32'd0);
    check("rst_mid_gpio_o", 32'(gpio_o), 32'd0);
    check("rst_mid_gpio_oe", 32'(gpio_oe), 32'd0);
    out_m = '0; dir_m = '0;
    @(negedge clk) rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("no_ack_after_rst", 32'(bus.ack), 32'd0);
    end

    model(1'b1, 2'd2, 1'b0, 32'h40, 32'h5555_AAAA, e_d, rd_d, lat_d);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd2; bus.addr = 32'h40; bus.wdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus.req = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_store_no_ack", 32'(bus.ack), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    bus_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0, r);
    check("store_kept_after_rst", r, 32'h5555_AAAA);

    for (int i = 0; i < 300; i++) begin
      logic        w, u;
      logic [1:0]  sz;
      logic [31:0] a;
      int          cat;
      if ($urandom_range(0, 9) == 0) begin
        gpio_i = GPIO_W'($urandom);
        repeat (2) @(posedge clk);
        #1;
        pins_m = 32'(gpio_i);
      end
      w   = 1'($urandom);
      u   = 1'($urandom);
      sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      cat = $urandom_range(0, 9);
      if (cat <= 4)      a = 32'($urandom_range(0, 255));
      else if (cat == 5) a = 32'h0FF0 + 32'($urandom_range(0, 15));
      else if (cat <= 7) a = 32'h1000_0000 + 32'($urandom_range(0, 15));
      else if (cat == 8) a = 32'h0000_1000 + 32'($urandom_range(0, 15));
      else               a = $urandom | 32'h2000_0000;
      bus_op(w, sz, u, a, $urandom, ($urandom_range(0, 3) == 0), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
